// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: holds the core in reset, counts run
// cycles, and ends the run on a repeated fetch PC (halt) or on a cycle limit (timeout).
module mips_run_ctrl #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RESET_CYCLES = 2,
    parameter int unsigned MAX_CYCLES   = 100000,
    parameter int unsigned HALT_REPEAT  = 4,
    parameter int unsigned AUTO_START   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc_in,
    input  logic             pc_valid,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  halt_pc
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int unsigned REP_W  = $clog2(HALT_REPEAT + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_HALT  = REP_W'(HALT_REPEAT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic [REP_W-1:0]  rep_cnt, rep_cnt_nx, rep_inc;
    logic [PC_W-1:0]   last_pc, last_pc_nx;
    logic              last_ok, last_ok_nx;
    logic              cpu_reset_nx, running_nx, done_nx, timeout_nx;
    logic [CNT_W-1:0]  cycle_count_nx, cnt_inc;
    logic [PC_W-1:0]   halt_pc_nx;
    logic              halt_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= (AUTO_START != 0) ? HOLD : IDLE;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            last_pc     <= '0;
            last_ok     <= 1'b0;
            cpu_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            halt_pc     <= '0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_cnt_nx;
            rep_cnt     <= rep_cnt_nx;
            last_pc     <= last_pc_nx;
            last_ok     <= last_ok_nx;
            cpu_reset   <= cpu_reset_nx;
            running     <= running_nx;
            done        <= done_nx;
            timeout     <= timeout_nx;
            cycle_count <= cycle_count_nx;
            halt_pc     <= halt_pc_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        hold_cnt_nx    = hold_cnt;
        rep_cnt_nx     = rep_cnt;
        last_pc_nx     = last_pc;
        last_ok_nx     = last_ok;
        cpu_reset_nx   = cpu_reset;
        running_nx     = running;
        done_nx        = done;
        timeout_nx     = timeout;
        cycle_count_nx = cycle_count;
        halt_pc_nx     = halt_pc;
        cnt_inc        = cycle_count + CNT_W'(1);
        rep_inc        = rep_cnt + REP_W'(1);
        halt_hit       = 1'b0;

        case (state)
            IDLE, DONE: begin
                cpu_reset_nx = 1'b1;
                running_nx   = 1'b0;
                // IDLE and DONE share the restart path; the status is cleared as HOLD begins
                if (start) begin
                    state_nx       = HOLD;
                    hold_cnt_nx    = '0;
                    rep_cnt_nx     = '0;
                    last_ok_nx     = 1'b0;
                    done_nx        = 1'b0;
                    timeout_nx     = 1'b0;
                    cycle_count_nx = '0;
                    halt_pc_nx     = '0;
                end
            end
            HOLD: begin
                cpu_reset_nx = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_nx     = RUN;
                    hold_cnt_nx  = '0;
                    cpu_reset_nx = 1'b0;
                    running_nx   = 1'b1;
                end else begin
                    hold_cnt_nx = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                cycle_count_nx = cnt_inc;
                if (pc_valid) begin
                    if (last_ok && (pc_in == last_pc)) begin
                        rep_cnt_nx = rep_inc;
                        halt_hit   = (rep_inc == REP_HALT);
                    end else begin
                        rep_cnt_nx = REP_W'(1);
                        last_pc_nx = pc_in;
                        last_ok_nx = 1'b1;
                    end
                end
                // halt takes priority over a timeout landing on the same edge
                if (halt_hit || (cnt_inc == CNT_MAX)) begin
                    state_nx     = DONE;
                    done_nx      = 1'b1;
                    timeout_nx   = !halt_hit;
                    cpu_reset_nx = 1'b1;
                    running_nx   = 1'b0;
                    if (halt_hit) halt_pc_nx = pc_in;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: expected run results are queued as each PC
// sequence is driven and checked against the DUT status when the run ends.
module tb_mips_run_ctrl;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned RC    = 2;
    localparam int unsigned MAXC  = 50;
    localparam int unsigned HR    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             start_i = 1'b0;
    logic [PC_W-1:0]  pc_in = '0;
    logic             pc_valid = 1'b0;

    logic             cpu_reset, running, done, timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [PC_W-1:0]  halt_pc;

    logic             i_cpu_reset, i_running, i_done, i_timeout;
    logic [CNT_W-1:0] i_cycle_count;
    logic [PC_W-1:0]  i_halt_pc;

    mips_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
        .HALT_REPEAT(HR), .AUTO_START(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .pc_valid(pc_valid),
        .cpu_reset(cpu_reset), .running(running), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .halt_pc(halt_pc)
    );

    mips_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RESET_CYCLES(RC), .MAX_CYCLES(MAXC),
        .HALT_REPEAT(HR), .AUTO_START(0)
    ) dut_idle (
        .clk(clk), .reset(reset), .start(start_i), .pc_in(pc_in), .pc_valid(pc_valid),
        .cpu_reset(i_cpu_reset), .running(i_running), .done(i_done), .timeout(i_timeout),
        .cycle_count(i_cycle_count), .halt_pc(i_halt_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [PC_W-1:0]  hpc;
        logic             to;
    } exp_t;

    exp_t            sb[$];
    int              n_checks = 0;
    int              n_fail = 0;
    logic [PC_W-1:0] seq_pc[64];
    logic            seq_v[64];
    logic            seq_s[64];
    int              seq_len = 0;

    task automatic clear_seq();
        seq_len = 0;
    endtask

    task automatic add(input logic [PC_W-1:0] pc, input logic v, input logic s);
        seq_pc[seq_len] = pc;
        seq_v[seq_len]  = v;
        seq_s[seq_len]  = s;
        seq_len++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; start = 1'b0; start_i = 1'b0; pc_valid = 1'b0; pc_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_running();
        int k;
        k = 0;
        while (running !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (running !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_running: running=%b required 1 within 20 cycles", running);
        end
    endtask

    // Drives the prepared sequence, one element per RUN edge, and checks the end-of-run status.
    task automatic drive_seq(input logic [CNT_W-1:0] ecnt, input logic [PC_W-1:0] ehpc, input logic eto);
        exp_t e;
        logic early;
        e.cnt = ecnt; e.hpc = ehpc; e.to = eto;
        sb.push_back(e);
        early = 1'b0;
        for (int i = 0; i < seq_len; i++) begin
            pc_in    = seq_pc[i];
            pc_valid = seq_v[i];
            start    = seq_s[i];
            @(negedge clk);
            start = 1'b0;
            if (i < seq_len - 1 && done !== 1'b0) early = 1'b1;
        end
        pc_valid = 1'b0;
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL early_done: done rose before the final sample, required 0");
        end
        e = sb.pop_front();
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL run_done: got %b required 1", done); end
        n_checks++;
        if (timeout !== e.to) begin n_fail++; $display("FAIL run_timeout: got %b required %b", timeout, e.to); end
        n_checks++;
        if (cycle_count !== e.cnt) begin n_fail++; $display("FAIL run_cycle_count: got %0d required %0d", cycle_count, e.cnt); end
        n_checks++;
        if (halt_pc !== e.hpc) begin n_fail++; $display("FAIL run_halt_pc: got %h required %h", halt_pc, e.hpc); end
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL run_end_ctrl: cpu_reset=%b running=%b required 1/0", cpu_reset, running);
        end
    endtask

    task automatic build_halt_seq(input int start_idx);
        clear_seq();
        for (int i = 0; i < 4; i++) add(32'h3000 + 32'(4 * i), 1'b1, (i == start_idx));
        for (int i = 0; i < 4; i++) add(32'h3010, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || timeout !== 1'b0
            || cycle_count !== '0 || halt_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_values: cpu_reset=%b running=%b done=%b timeout=%b cnt=%0d hpc=%h required 1/0/0/0/0/0",
                     cpu_reset, running, done, timeout, cycle_count, halt_pc);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0) begin
            n_fail++; $display("FAIL hold_cycle2: cpu_reset=%b running=%b required 1/0", cpu_reset, running);
        end
        @(negedge clk);
        n_checks++;
        if (cpu_reset !== 1'b0 || running !== 1'b1 || cycle_count !== '0) begin
            n_fail++; $display("FAIL run_entry: cpu_reset=%b running=%b cnt=%0d required 0/1/0", cpu_reset, running, cycle_count);
        end
        @(negedge clk);
        n_checks++;
        if (cycle_count !== 32'd1) begin
            n_fail++; $display("FAIL first_count: got %0d required 1", cycle_count);
        end
    endtask

    task automatic test_idle();
        apply_reset();
        repeat (4) @(negedge clk);
        n_checks++;
        if (i_cpu_reset !== 1'b1 || i_running !== 1'b0) begin
            n_fail++; $display("FAIL idle_wait: cpu_reset=%b running=%b required 1/0", i_cpu_reset, i_running);
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_cpu_reset !== 1'b1 || i_running !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: cpu_reset=%b running=%b required 1/0", i_cpu_reset, i_running);
        end
        @(negedge clk);
        n_checks++;
        if (i_cpu_reset !== 1'b0 || i_running !== 1'b1) begin
            n_fail++; $display("FAIL idle_run: cpu_reset=%b running=%b required 0/1", i_cpu_reset, i_running);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        wait_running();
        build_halt_seq(-1);
        drive_seq(32'd8, 32'h3010, 1'b0);
    endtask

    task automatic test_stall();
        apply_reset();
        wait_running();
        clear_seq();
        for (int i = 0; i < 4; i++) add(32'h3000 + 32'(4 * i), 1'b1, 1'b0);
        add(32'h3010, 1'b1, 1'b0);
        add(32'h3010, 1'b1, 1'b0);
        add(32'h9999, 1'b0, 1'b0);
        add(32'h9999, 1'b0, 1'b0);
        add(32'h3010, 1'b1, 1'b0);
        add(32'h3010, 1'b1, 1'b0);
        drive_seq(32'd10, 32'h3010, 1'b0);
    endtask

    task automatic test_timeout();
        apply_reset();
        wait_running();
        clear_seq();
        for (int i = 0; i < 50; i++) add(32'h4000 + 32'(4 * i), 1'b1, 1'b0);
        drive_seq(32'd50, 32'h0, 1'b1);
        pc_in = 32'h7777;
        pc_valid = 1'b1;
        repeat (5) @(negedge clk);
        pc_valid = 1'b0;
        n_checks++;
        if (cycle_count !== 32'd50 || done !== 1'b1 || timeout !== 1'b1) begin
            n_fail++; $display("FAIL timeout_frozen: cnt=%0d done=%b timeout=%b required 50/1/1", cycle_count, done, timeout);
        end
    endtask

    task automatic test_restart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || timeout !== 1'b0 || cycle_count !== '0 || halt_pc !== '0) begin
            n_fail++; $display("FAIL restart_clear: done=%b timeout=%b cnt=%0d hpc=%h required 0/0/0/0", done, timeout, cycle_count, halt_pc);
        end
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0) begin
            n_fail++; $display("FAIL restart_hold1: cpu_reset=%b running=%b required 1/0", cpu_reset, running);
        end
        @(negedge clk);
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0) begin
            n_fail++; $display("FAIL restart_hold2: cpu_reset=%b running=%b required 1/0", cpu_reset, running);
        end
        @(negedge clk);
        n_checks++;
        if (cpu_reset !== 1'b0 || running !== 1'b1) begin
            n_fail++; $display("FAIL restart_run: cpu_reset=%b running=%b required 0/1", cpu_reset, running);
        end
        // previous run ended tracking 0x40C4; a fresh repeat count must need all four samples
        clear_seq();
        for (int i = 0; i < 4; i++) add(32'h40C4, 1'b1, 1'b0);
        drive_seq(32'd4, 32'h40C4, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (halt_pc !== '0 || done !== 1'b0 || cycle_count !== '0) begin
            n_fail++; $display("FAIL restart_after_halt: hpc=%h done=%b cnt=%0d required 0/0/0", halt_pc, done, cycle_count);
        end
    endtask

    task automatic test_halt_at_max();
        apply_reset();
        wait_running();
        clear_seq();
        for (int i = 0; i < 46; i++) add(32'h5000 + 32'(4 * i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) add(32'h5100, 1'b1, 1'b0);
        drive_seq(32'd50, 32'h5100, 1'b0);
    endtask

    task automatic test_start_in_run();
        apply_reset();
        wait_running();
        build_halt_seq(2);
        drive_seq(32'd8, 32'h3010, 1'b0);
    endtask

    task automatic test_reset_abort();
        apply_reset();
        wait_running();
        for (int i = 0; i < 5; i++) begin
            pc_in = 32'h6000 + 32'(4 * i);
            pc_valid = 1'b1;
            @(negedge clk);
        end
        pc_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0 || cycle_count !== '0 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_run: cpu_reset=%b running=%b cnt=%0d done=%b required 1/0/0/0", cpu_reset, running, cycle_count, done);
        end
        reset = 1'b0;
        wait_running();
        build_halt_seq(-1);
        drive_seq(32'd8, 32'h3010, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (halt_pc !== '0 || done !== 1'b0 || cycle_count !== '0 || cpu_reset !== 1'b1) begin
            n_fail++; $display("FAIL abort_done: hpc=%h done=%b cnt=%0d cpu_reset=%b required 0/0/0/1", halt_pc, done, cycle_count, cpu_reset);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_halt();
        test_stall();
        test_timeout();
        test_restart();
        test_halt_at_max();
        test_start_in_run();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised CPU run controller for the pipelined MIPS top level.
- Generates a programmable-length synchronous reset for the core, then counts run cycles.
- Watches the fetch PC and detects end of program: the same PC sampled repeatedly, which is the `beq $0,$0,-1` idiom.
- Terminates the run with a done/timeout status, and supports restart without a global reset.

Parameters:
- PC_W, 32: width of the monitored PC.
- CNT_W, 32: width of the run-cycle counter.
- RESET_CYCLES, 2: cycles the core reset is held after leaving reset or on restart. Must be ≥1.
- MAX_CYCLES, 100000: run-cycle limit before timeout. Must be ≥1 and < 2^CNT_W.
- HALT_REPEAT, 4: number of consecutive valid equal-PC samples that declares halt. Must be ≥2.
- AUTO_START, 1: 1 = begin the reset-hold sequence straight out of reset; 0 = wait in IDLE for start.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset of this block.
- start  input  1  single-cycle restart request; honoured only in IDLE and DONE.
- pc_in  input  PC_W  fetch-stage PC of the core.
- pc_valid  input  1  pc_in is meaningful this cycle (fetch not stalled/bubbled).
- cpu_reset  output  1  reset driven to the core, active-high, registered.
- running  output  1  core is in its run phase.
- done  output  1  run finished; sticky until restart or reset.
- timeout  output  1  qualifies done: the run ended on MAX_CYCLES, not on halt.
- cycle_count  output  CNT_W  completed run cycles.
- halt_pc  output  PC_W  PC at which halt was detected.

Behaviour:
- Clock and reset: clk is the only clock; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - cpu_reset=1, running=0, done=0, timeout=0, cycle_count=0, halt_pc=0.
  - Internal: hold_cnt=0, rep_cnt=0, last_pc=0, last_ok=0.
  - Next state is HOLD if AUTO_START=1, else IDLE.
  - reset mid-run aborts everything identically.
- States: IDLE, HOLD, RUN, DONE.
- IDLE:
  - cpu_reset=1, running=0.
  - start=1 → HOLD, and clears done, timeout, cycle_count and halt_pc.
- HOLD:
  - cpu_reset=1.
  - hold_cnt increments each cycle. On the edge where hold_cnt==RESET_CYCLES-1: → RUN, hold_cnt=0, cpu_reset=0, running=1.
  - Net effect: cpu_reset is high for exactly RESET_CYCLES cycles after reset deasserts (AUTO_START=1) or after the start edge.
  - start is ignored.
- RUN:
  - cpu_reset=0, running=1. cycle_count increments every cycle.
  - PC tracking, on each valid sample (pc_valid=1):
    - If last_ok and pc_in==last_pc: rep_cnt++.
    - Otherwise: rep_cnt=1, last_pc=pc_in, last_ok=1.
  - pc_valid=0: rep_cnt and last_pc hold; a stall does not break a repeat run.
  - Halt: a valid sample that brings rep_cnt to HALT_REPEAT → DONE on that edge. halt_pc=pc_in, done=1, timeout=0.
  - Timeout: the edge on which cycle_count becomes MAX_CYCLES, with no halt on that edge → DONE, done=1, timeout=1.
  - Simultaneous halt and timeout: halt wins, timeout=0; cycle_count still records MAX_CYCLES.
  - start is ignored in RUN.
- DONE:
  - running=0, cpu_reset=1 (freezes the core).
  - cycle_count, halt_pc, done and timeout are frozen.
  - start=1 → HOLD; clears done, timeout, cycle_count, halt_pc, rep_cnt and last_ok.
- Arithmetic: all counters are unsigned. cycle_count never exceeds MAX_CYCLES. PC comparison is full-width equality.

Test Plan:
- Reset held 3 cycles then released, AUTO_START=1, RESET_CYCLES=2 → cpu_reset high for exactly 2 cycles after release; running=1 on the 3rd cycle; cycle_count=1 one edge later.
- Incrementing PC 0x3000, 0x3004, … then constant 0x3010 with pc_valid=1, HALT_REPEAT=4 → done=1 one edge after the 4th consecutive 0x3010 sample; halt_pc=0x3010; timeout=0; cpu_reset=1.
- Same sequence with pc_valid=0 for 2 cycles between the 2nd and 3rd 0x3010 samples → halt still declared after 4 valid samples; cycle_count is 2 larger than in the previous test.
- MAX_CYCLES=50 with a PC that never repeats → done=1, timeout=1, cycle_count=50 and frozen afterwards.
- Halt reached on the edge where cycle_count becomes MAX_CYCLES → timeout=0, halt_pc valid, cycle_count=MAX_CYCLES.
- After done, pulse start → done/timeout/cycle_count cleared, cpu_reset high for RESET_CYCLES, then a new run. Also: start during RUN has no effect; reset asserted mid-RUN → cpu_reset=1, all outputs back to reset values.
